mult_div_unit: RTL and testbench

- Sequential signed 32-bit multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the multicycle control unit, which drives start and op (from Div_Mult_Ctrl) and waits on done.
- Feeds the DIV0 exception flag back to the control unit; HI/LO feed the MemToReg mux for MFHI/MFLO.
- Operands come from the A/B registers.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_step.sv | 63 ++++++
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the op encoding, the FSM state encoding, the default operand width
// and the iteration counter width.
package mult_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   op        : OP_MULT selects a radix-2 Booth step, OP_DIV a restoring step
//   acc       : Booth accumulator / partial remainder
//   work      : multiplier being shifted out / quotient being shifted in
//   q1        : Booth q-1 bit (unused for divide, passed through)
//   m         : multiplicand (signed) / divisor magnitude (unsigned)
//   acc_next, work_next, q1_next : register values after this iteration
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] work,
  input  logic             q1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] work_next,
  output logic             q1_next
);

  logic signed [WIDTH:0] acc_ext;
  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] sum;
  logic        [WIDTH:0] shifted;
  logic        [WIDTH:0] diff;

  always_comb begin
    acc_ext   = $signed({acc[WIDTH-1], acc});
    m_ext     = $signed({m[WIDTH-1], m});
    sum       = acc_ext;
    shifted   = {acc, work[WIDTH-1]};
    diff      = shifted - {1'b0, m};
    acc_next  = acc;
    work_next = work;
    q1_next   = q1;

    if (op == OP_MULT) begin
      case ({work[0], q1})
        2'b01:   sum = acc_ext + m_ext;
        2'b10:   sum = acc_ext - m_ext;
        default: sum = acc_ext;
      endcase
      // The add/sub is done one bit wider so that a -2^(W-1) multiplicand
      // cannot overflow before the arithmetic shift brings it back in range.
      acc_next  = sum[WIDTH:1];
      work_next = {sum[0], work[WIDTH-1:1]};
      q1_next   = work[0];
    end else begin
      // Remainder is always below the divisor, so a set MSB of the
      // one-bit-wider difference means the trial subtraction went negative.
      if (!diff[WIDTH]) begin
        acc_next  = diff[WIDTH-1:0];
        work_next = {work[WIDTH-2:0], 1'b1};
      end else begin
        acc_next  = shifted[WIDTH-1:0];
        work_next = {work[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit with architectural HI/LO registers.
// MULT: Booth radix-2, 64-bit product in {hi, lo}.
// DIV : restoring division on magnitudes, lo = quotient (toward zero),
//       hi = remainder with the sign of the dividend.
// Ports:
//   clk, reset_in (sync, active-high)
//   start  : one-cycle request, sampled only in IDLE
//   op     : 0 = MULT, 1 = DIV
//   a, b   : signed operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo : result registers
//   busy   : high while iterating
//   done   : one-cycle completion pulse
//   div0   : divide-by-zero pulse, coincident with done
// Optional build macro MULT_DIV_EARLY_OUT_EN: zero-operand cases skip the
// iterations and finish one edge after start with hi = lo = 0.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic                    start,
  input  logic                    op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH-1:0] hi,
  output logic        [WIDTH-1:0] lo,
  output logic                    busy,
  output logic                    done,
  output logic                    div0
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             op_r;
  logic             sign_a;
  logic             sign_b;
  logic             div0_flag;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] m;
  logic             q1;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] work_next;
  logic             q1_next;
  logic             div_by_zero;
  logic             early_zero;
  logic             last_iter;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Negation of 2^(W-1) wraps to itself, which gives the expected
  // most-negative / -1 result without any special case.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    return neg ? -mag : mag;
  endfunction

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_r),
    .acc       (acc),
    .work      (work),
    .q1        (q1),
    .m         (m),
    .acc_next  (acc_next),
    .work_next (work_next),
    .q1_next   (q1_next)
  );

  always_comb begin
    div_by_zero = (op == OP_DIV) && (b == '0);
`ifdef MULT_DIV_EARLY_OUT_EN
    early_zero  = ((op == OP_MULT) && ((a == '0) || (b == '0))) ||
                  ((op == OP_DIV) && (a == '0) && (b != '0));
`else
    early_zero  = 1'b0;
`endif
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    div0       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (div_by_zero || early_zero) state_next = FINISH;
          else                           state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        div0       = div0_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and architectural result registers
  always_ff @(posedge clk) begin
    if (reset_in) begin
      cnt       <= '0;
      div0_flag <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            div0_flag <= div_by_zero;
            if (!div_by_zero && early_zero) begin
              hi <= '0;
              lo <= '0;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            if (op_r == OP_MULT) begin
              hi <= acc_next;
              lo <= work_next;
            end else begin
              lo <= apply_sign(work_next, sign_a ^ sign_b);
              hi <= apply_sign(acc_next, sign_a);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Working registers: loaded at start, iterated in RUN, never reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r   <= op;
      sign_a <= a[WIDTH-1];
      sign_b <= b[WIDTH-1];
      acc    <= '0;
      q1     <= 1'b0;
      if (op == OP_MULT) begin
        m    <= a;
        work <= b;
      end else begin
        m    <= magnitude(b);
        work <= magnitude(a);
      end
    end else if (state == RUN) begin
      acc  <= acc_next;
      work <= work_next;
      q1   <= q1_next;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a scoreboard queue holds the
// expected result of each started operation, popped when done is seen.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_in;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
    int          busy_n;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      r;
    logic [63:0] ru;
    bit          fast;
    sx = $signed(x);
    sy = $signed(y);
    e.div0   = 1'b0;
    e.lat    = 33;
    e.busy_n = 32;
    fast     = 1'b0;
`ifdef MULT_DIV_EARLY_OUT_EN
    fast = (o == 1'b0 && (x == 0 || y == 0)) || (o == 1'b1 && x == 0 && y != 0);
`endif
    if (o == 1'b0) begin
      r    = sx * sy;
      ru   = r;
      e.hi = ru[63:32];
      e.lo = ru[31:0];
    end else if (y == 0) begin
      e.hi   = cur_hi;
      e.lo   = cur_lo;
      e.div0 = 1'b1;
      fast   = 1'b1;
    end else begin
      r    = sx / sy;
      ru   = r;
      e.lo = ru[31:0];
      r    = sx % sy;
      ru   = r;
      e.hi = ru[31:0];
    end
    if (fast) begin
      e.lat    = 1;
      e.busy_n = 0;
    end
    return e;
  endfunction

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    exp_t e;
    int   edges;
    int   busy_n;
    sb.push_back(model(o, x, y, model_hi, model_lo));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    edges  = 1;
    busy_n = 0;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_n++;
      if (poke && edges == 5) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check_eq("done_seen", done, 1);
    check_eq("hi", hi, e.hi);
    check_eq("lo", lo, e.lo);
    check_eq("div0", div0, e.div0);
    check_eq("latency", edges, e.lat);
    check_eq("busy_cycles", busy_n, e.busy_n);
    model_hi = e.hi;
    model_lo = e.lo;
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("div0_one_cycle", div0, 0);
  endtask

  task automatic reset_mid_run();
    int pulses;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h0000_0456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("busy_before_abort", busy, 1);
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    model_hi = '0;
    model_lo = '0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check_eq("abort_no_done", pulses, 0);
  endtask

  task automatic reset_with_start();
    int pulses;
    @(negedge clk);
    reset_in = 1'b1; start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    reset_in = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (5) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    check_eq("reset_beats_start", pulses, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    model_hi = '0; model_lo = '0;
    reset_in = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_in = 1'b0;
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_div0", div0, 0);

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b1, 32'd55, 32'd0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'd7, 1'b0);
    run_op(1'b0, 32'd1000, 32'hFFFF_FF00, 1'b1);
    reset_mid_run();
    run_op(1'b0, 32'd0, 32'd5, 1'b0);
    run_op(1'b1, 32'd0, 32'd5, 1'b0);
    run_op(1'b1, 32'd3, 32'd0, 1'b0);
    reset_with_start();
    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end
    run_op(1'b1, $urandom, 32'($urandom_range(1, 300)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
